// File: rtl/h80cpu_pkg.sv
// Shared bus types for the h80cpu family (CPU core, h80cpu_io, memory).
package h80cpu_pkg;

  localparam int BUS_CMD_W = 3;

  // Encodings 4..7 are undefined and complete with an error.
  typedef enum logic [BUS_CMD_W-1:0] {
    bus_cmd_read_w  = 3'd0,
    bus_cmd_write_w = 3'd1,
    bus_cmd_read_b  = 3'd2,
    bus_cmd_write_b = 3'd3
  } bus_cmd_t;

  typedef logic [15:0] bus_addr_t;
  typedef logic [15:0] bus_data_t;

  // Memory controller sequencing.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } mem_state_t;

endpackage

// File: rtl/h80cpu_rr_arbiter.sv
// Round-robin pick of the first pending channel after the last granted one.
// Purely combinational; the last-granted register is owned by the parent.
module h80cpu_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] pend_i,
  input  logic [CW-1:0]     last_i,
  output logic [CW-1:0]     gnt_o,
  output logic              valid_o
);

  int c_idx;

  // Scan channels last+1, last+2, ... wrapping, and take the first pending one.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    c_idx   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c_idx = (int'(last_i) + k) % NUM_CH;
      if (!valid_o && pend_i[c_idx]) begin
        valid_o = 1'b1;
        gnt_o   = c_idx[CW-1:0];
      end
    end
  end

endmodule

// File: rtl/h80cpu_mem_mp.sv
// Multi-port word/byte memory for the h80cpu family. NUM_CH toggle-handshake
// requesters share one synchronous single-port RAM through a round-robin
// arbiter, with optional wait states and an out-of-range error flag.
//
//   state    | meaning
//   S_IDLE   | arbitrate; latch winner's request, issue the RAM read
//   S_WAIT   | burn WAIT_CYCLES wait states
//   S_ACCESS | complete: RAM write / rd_data / err update, toggle done
module h80cpu_mem_mp
  import h80cpu_pkg::*;
#(
  parameter int    DATA_W      = 16,
  parameter int    ADDR_W      = 16,
  parameter int    DEPTH_WORDS = 32768,
  parameter int    NUM_CH      = 2,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_run_i,
  input  logic [NUM_CH*BUS_CMD_W-1:0] ch_cmd_i,
  input  logic [NUM_CH*ADDR_W-1:0]    ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]    ch_wr_data_i,
  output logic [NUM_CH*DATA_W-1:0]    ch_rd_data_o,
  output logic [NUM_CH-1:0]           ch_done_o,
  output logic [NUM_CH-1:0]           ch_err_o
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]    WAIT_LD  = 4'(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST_RST = CW'(NUM_CH - 1);

  function automatic logic [31:0] word_idx(input logic [ADDR_W-1:0] a);
    return 32'(a) >> LB;
  endfunction

  function automatic logic [31:0] lane_of(input logic [ADDR_W-1:0] a);
    return 32'(a) & ((32'd1 << LB) - 32'd1);
  endfunction

  mem_state_t               state_q, state_d;
  logic [3:0]               wait_q, wait_d;
  logic [CW-1:0]            last_q, last_d, gch_q, gnt;
  logic                     gnt_vld;
  logic [BUS_CMD_W-1:0]     cmd_q;
  logic [ADDR_W-1:0]        addr_q, gnt_addr;
  logic [DATA_W-1:0]        wdata_q;
  logic [NUM_CH*DATA_W-1:0] rd_data_q;
  logic [NUM_CH-1:0]        done_q, err_q, pend;

  logic [DATA_W-1:0]        mem [DEPTH_WORDS];
  logic [DATA_W-1:0]        mem_rd_q;
  logic [AW-1:0]            mem_adr;
  logic                     mem_re, mem_we;

  logic [31:0]              gnt_idx, acc_idx, acc_lane;
  logic                     acc_rng, acc_we, acc_rd_upd, acc_err;
  logic [7:0]               acc_byte;
  logic [DATA_W-1:0]        acc_merge, acc_wdata, acc_rdata;

  assign pend         = ch_run_i ^ done_q;
  assign ch_done_o    = done_q;
  assign ch_err_o     = err_q;
  assign ch_rd_data_o = rd_data_q;

  h80cpu_rr_arbiter #(.NUM_CH(NUM_CH), .CW(CW)) u_arb (
    .pend_i  (pend),
    .last_i  (last_q),
    .gnt_o   (gnt),
    .valid_o (gnt_vld)
  );

  assign gnt_addr = ch_addr_i[int'(gnt)*ADDR_W +: ADDR_W];
  assign gnt_idx  = word_idx(gnt_addr);
  assign acc_idx  = word_idx(addr_q);
  assign acc_lane = lane_of(addr_q);
  assign acc_rng  = acc_idx < 32'(DEPTH_WORDS);

  // The RAM is read at grant and written at access, so one address port suffices.
  assign mem_re  = (state_q == S_IDLE) && gnt_vld && (gnt_idx < 32'(DEPTH_WORDS));
  assign mem_we  = (state_q == S_ACCESS) && acc_we && !reset;
  assign mem_adr = (state_q == S_ACCESS) ? acc_idx[AW-1:0] : gnt_idx[AW-1:0];

  // Single-port synchronous RAM; contents survive reset.
  always_ff @(posedge sysclk) begin
    if (mem_we) mem[mem_adr] <= acc_wdata;
    if (mem_re) mem_rd_q <= mem[mem_adr];
  end

  // Decode the latched command against the registered RAM word.
  always_comb begin
    acc_byte   = '0;
    acc_merge  = mem_rd_q;
    acc_we     = 1'b0;
    acc_wdata  = wdata_q;
    acc_rd_upd = 1'b0;
    acc_rdata  = '0;
    acc_err    = !acc_rng;
    for (int l = 0; l < NB; l++) begin
      if (32'(l) == acc_lane) begin
        acc_byte            = mem_rd_q[l*8 +: 8];
        acc_merge[l*8 +: 8] = wdata_q[7:0];
      end
    end
    case (cmd_q)
      bus_cmd_read_w: begin
        acc_rd_upd = 1'b1;
        acc_rdata  = acc_rng ? mem_rd_q : '0;
      end
      bus_cmd_write_w: acc_we = acc_rng;
      bus_cmd_read_b: begin
        acc_rd_upd = 1'b1;
        acc_rdata  = acc_rng ? DATA_W'(acc_byte) : '0;
      end
      bus_cmd_write_b: begin
        acc_we    = acc_rng;
        acc_wdata = acc_merge;
      end
      default: acc_err = 1'b1;
    endcase
  end

  // Next-state logic for the sequencer, wait counter and round-robin pointer.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          wait_d  = WAIT_LD;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        last_d  = gch_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers, request latch and per-channel completion status.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      last_q    <= LAST_RST;
      gch_q     <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      done_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      last_q  <= last_d;
      if (state_q == S_IDLE && gnt_vld) begin
        gch_q   <= gnt;
        cmd_q   <= ch_cmd_i[int'(gnt)*BUS_CMD_W +: BUS_CMD_W];
        addr_q  <= gnt_addr;
        wdata_q <= ch_wr_data_i[int'(gnt)*DATA_W +: DATA_W];
      end
      if (state_q == S_ACCESS) begin
        done_q[gch_q] <= ~done_q[gch_q];
        err_q[gch_q]  <= acc_err;
        if (acc_rd_upd) rd_data_q[int'(gch_q)*DATA_W +: DATA_W] <= acc_rdata;
      end
    end
  end

endmodule

// File: tb/tb_h80cpu_mem_mp.sv
// Directed bench for h80cpu_mem_mp: three instances cover 16-bit/no-wait,
// 16-bit/3-wait and 32-bit/3-channel configurations.
`timescale 1ns/1ps
module tb_h80cpu_mem_mp;
  import h80cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ac, rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  // dut A: 16-bit, 2 ch, WAIT 0, 1000 words
  logic [1:0]  run_a, done_a, err_a;
  logic [5:0]  cmd_a;
  logic [31:0] addr_a, wd_a, rd_a;
  // dut B: 16-bit, 2 ch, WAIT 3, 1000 words
  logic [1:0]  run_b, done_b, err_b;
  logic [5:0]  cmd_b;
  logic [31:0] addr_b, wd_b, rd_b;
  // dut C: 32-bit, 3 ch, WAIT 0, 64 words
  logic [2:0]  run_c, done_c, err_c;
  logic [8:0]  cmd_c;
  logic [47:0] addr_c;
  logic [95:0] wd_c, rd_c;

  h80cpu_mem_mp #(.DATA_W(16), .ADDR_W(16), .DEPTH_WORDS(1000), .NUM_CH(2), .WAIT_CYCLES(0)) dut_a (
    .sysclk(clk), .reset(rst_ac), .ch_run_i(run_a), .ch_cmd_i(cmd_a), .ch_addr_i(addr_a),
    .ch_wr_data_i(wd_a), .ch_rd_data_o(rd_a), .ch_done_o(done_a), .ch_err_o(err_a));

  h80cpu_mem_mp #(.DATA_W(16), .ADDR_W(16), .DEPTH_WORDS(1000), .NUM_CH(2), .WAIT_CYCLES(3)) dut_b (
    .sysclk(clk), .reset(rst_b), .ch_run_i(run_b), .ch_cmd_i(cmd_b), .ch_addr_i(addr_b),
    .ch_wr_data_i(wd_b), .ch_rd_data_o(rd_b), .ch_done_o(done_b), .ch_err_o(err_b));

  h80cpu_mem_mp #(.DATA_W(32), .ADDR_W(16), .DEPTH_WORDS(64), .NUM_CH(3), .WAIT_CYCLES(0)) dut_c (
    .sysclk(clk), .reset(rst_ac), .ch_run_i(run_c), .ch_cmd_i(cmd_c), .ch_addr_i(addr_c),
    .ch_wr_data_i(wd_c), .ch_rd_data_o(rd_c), .ch_done_o(done_c), .ch_err_o(err_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_done(input int d, input int ch);
    case (d)
      0:       return done_a[ch];
      1:       return done_b[ch];
      default: return done_c[ch];
    endcase
  endfunction

  function automatic logic get_run(input int d, input int ch);
    case (d)
      0:       return run_a[ch];
      1:       return run_b[ch];
      default: return run_c[ch];
    endcase
  endfunction

  function automatic logic get_err(input int d, input int ch);
    case (d)
      0:       return err_a[ch];
      1:       return err_b[ch];
      default: return err_c[ch];
    endcase
  endfunction

  function automatic logic [31:0] get_rd(input int d, input int ch);
    case (d)
      0:       return 32'(rd_a[ch*16 +: 16]);
      1:       return 32'(rd_b[ch*16 +: 16]);
      default: return rd_c[ch*32 +: 32];
    endcase
  endfunction

  task automatic drive(input int d, input int ch, input logic [2:0] cmd,
                       input logic [15:0] addr, input logic [31:0] wd);
    case (d)
      0: begin
        cmd_a[ch*3 +: 3] = cmd; addr_a[ch*16 +: 16] = addr; wd_a[ch*16 +: 16] = wd[15:0];
        run_a[ch] = ~run_a[ch];
      end
      1: begin
        cmd_b[ch*3 +: 3] = cmd; addr_b[ch*16 +: 16] = addr; wd_b[ch*16 +: 16] = wd[15:0];
        run_b[ch] = ~run_b[ch];
      end
      default: begin
        cmd_c[ch*3 +: 3] = cmd; addr_c[ch*16 +: 16] = addr; wd_c[ch*32 +: 32] = wd;
        run_c[ch] = ~run_c[ch];
      end
    endcase
  endtask

  // Issue one request and wait (bounded) for its done toggle; checks latency.
  task automatic req(input int d, input int ch, input logic [2:0] cmd, input logic [15:0] addr,
                     input logic [31:0] wd, input int exp_lat, input string tag);
    int cyc = 0;
    drive(d, ch, cmd, addr, wd);
    while (get_done(d, ch) != get_run(d, ch) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
  endtask

  task automatic rd_chk(input int d, input int ch, input string tag,
                        input logic [31:0] exp_rd, input logic exp_err);
    check({tag, " rd_data"}, get_rd(d, ch), exp_rd);
    check({tag, " err"}, 32'(get_err(d, ch)), 32'(exp_err));
  endtask

  // All nch channels request together and re-request right after each done.
  // Completions must rotate starting at 'first', one every per_cyc cycles.
  task automatic rr(input int d, input int nch, input int per, input int per_cyc,
                    input int first, input logic [15:0] addr, input string tag);
    int rem[3];
    logic [2:0] seen;
    int cnt = 0;
    int cyc = 0;
    seen = '0;
    for (int ch = 0; ch < nch; ch++) begin
      seen[ch] = get_done(d, ch);
      rem[ch]  = per - 1;
      drive(d, ch, bus_cmd_read_w, addr, 32'h0);
    end
    while (cnt < nch * per && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      for (int ch = 0; ch < nch; ch++) begin
        if (get_done(d, ch) != seen[ch]) begin
          seen[ch] = get_done(d, ch);
          check($sformatf("%s order %0d", tag, cnt), 32'(ch), 32'((first + cnt) % nch));
          check($sformatf("%s cycle %0d", tag, cnt), 32'(cyc), 32'((cnt + 1) * per_cyc));
          cnt++;
          if (rem[ch] > 0) begin
            drive(d, ch, bus_cmd_read_w, addr, 32'h0);
            rem[ch]--;
          end
        end
      end
    end
    check({tag, " completions"}, 32'(cnt), 32'(nch * per));
  endtask

  initial begin
    rst_ac = 1'b1; rst_b = 1'b1;
    run_a = '0; cmd_a = '0; addr_a = '0; wd_a = '0;
    run_b = '0; cmd_b = '0; addr_b = '0; wd_b = '0;
    run_c = '0; cmd_c = '0; addr_c = '0; wd_c = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_ac = 1'b0; rst_b = 1'b0;

    check("A reset done", 32'(done_a), 32'h0);
    check("A reset err", 32'(err_a), 32'h0);
    check("A reset rd", rd_a, 32'h0);
    check("C reset done", 32'(done_c), 32'h0);

    // ---- dut A: word/byte access, error cases
    req(0, 0, bus_cmd_write_w, 16'h0010, 32'h1234, 2, "A wr_w 0x10");
    check("A wr_w err", 32'(err_a[0]), 32'h0);
    req(0, 0, bus_cmd_read_w, 16'h0010, 32'h0, 2, "A rd_w 0x10");
    rd_chk(0, 0, "A rd_w 0x10", 32'h1234, 1'b0);
    req(0, 0, bus_cmd_write_b, 16'h0011, 32'hFFAB, 2, "A wr_b 0x11");
    req(0, 0, bus_cmd_read_w, 16'h0010, 32'h0, 2, "A rd_w merged");
    rd_chk(0, 0, "A rd_w merged", 32'hAB34, 1'b0);
    req(0, 0, bus_cmd_read_b, 16'h0011, 32'h0, 2, "A rd_b 0x11");
    rd_chk(0, 0, "A rd_b 0x11", 32'h00AB, 1'b0);
    req(0, 0, bus_cmd_read_b, 16'h0010, 32'h0, 2, "A rd_b 0x10");
    rd_chk(0, 0, "A rd_b 0x10", 32'h0034, 1'b0);

    req(0, 0, bus_cmd_read_w, 16'h07D0, 32'h0, 2, "A rd oor");
    rd_chk(0, 0, "A rd oor", 32'h0, 1'b1);
    req(0, 0, bus_cmd_read_w, 16'h0010, 32'h0, 2, "A rd after oor");
    rd_chk(0, 0, "A rd after oor", 32'hAB34, 1'b0);

    req(0, 0, bus_cmd_write_w, 16'h0000, 32'h1111, 2, "A wr_w 0x0");
    req(0, 0, bus_cmd_write_w, 16'h0800, 32'h2222, 2, "A wr oor");
    check("A wr oor err", 32'(err_a[0]), 32'h1);
    req(0, 0, bus_cmd_read_w, 16'h0000, 32'h0, 2, "A rd 0x0");
    rd_chk(0, 0, "A rd 0x0", 32'h1111, 1'b0);
    req(0, 0, bus_cmd_write_w, 16'h07CE, 32'hBEEF, 2, "A wr last");
    req(0, 0, bus_cmd_read_w, 16'h07CE, 32'h0, 2, "A rd last");
    rd_chk(0, 0, "A rd last", 32'hBEEF, 1'b0);

    req(0, 1, bus_cmd_read_w, 16'h0010, 32'h0, 2, "A ch1 rd");
    rd_chk(0, 1, "A ch1 rd", 32'hAB34, 1'b0);
    req(0, 1, 3'd5, 16'h0010, 32'h0, 2, "A ch1 undef");
    rd_chk(0, 1, "A ch1 undef", 32'hAB34, 1'b1);
    req(0, 0, bus_cmd_read_w, 16'h0010, 32'h0, 2, "A rd after undef");
    rd_chk(0, 0, "A rd after undef", 32'hAB34, 1'b0);

    rr(0, 2, 4, 2, 1, 16'h0010, "A rr");

    // ---- dut B: wait states, round robin, reset during S_WAIT
    req(1, 0, bus_cmd_write_w, 16'h0020, 32'h5555, 5, "B wr_w 0x20");
    rr(1, 2, 4, 5, 1, 16'h0020, "B rr");
    rd_chk(1, 1, "B rr ch1 data", 32'h5555, 1'b0);

    drive(1, 0, bus_cmd_write_w, 16'h0020, 32'h9999);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_b = 1'b1; run_b = '0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    check("B abort done", 32'(done_b), 32'h0);
    check("B abort err", 32'(err_b), 32'h0);
    check("B abort rd", rd_b, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    check("B abort no done", 32'(done_b), 32'h0);
    req(1, 0, bus_cmd_read_w, 16'h0020, 32'h0, 5, "B rd after abort");
    rd_chk(1, 0, "B rd after abort", 32'h5555, 1'b0);

    // ---- dut C: 32-bit byte lanes, three channels
    for (int l = 0; l < 4; l++)
      req(2, 2, bus_cmd_write_b, 16'(16'h0040 + l), 32'(8'h11 * (l + 1)), 2,
          $sformatf("C wr_b lane%0d", l));
    req(2, 2, bus_cmd_read_w, 16'h0040, 32'h0, 2, "C rd_w 0x40");
    rd_chk(2, 2, "C rd_w 0x40", 32'h44332211, 1'b0);
    req(2, 0, bus_cmd_read_b, 16'h0042, 32'h0, 2, "C rd_b 0x42");
    rd_chk(2, 0, "C rd_b 0x42", 32'h00000033, 1'b0);
    rr(2, 3, 2, 2, 1, 16'h0040, "C rr");
    rd_chk(2, 1, "C rr ch1 data", 32'h44332211, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
